// File: rtl/ps2_block_entry_buffer.sv
// Multi-channel PS/2 scan-code entry buffer: per-channel byte blocks with backspace/clear,
// plus a single-slot commit register handed to the AES side over valid/ready.
module ps2_block_entry_buffer #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DW         = 8,
  parameter logic [DW-1:0] BKSP_CODE  = 8'h66,
  parameter logic [DW-1:0] ENTER_CODE = 8'h5A,
  parameter logic [DW-1:0] PAD_CODE   = 8'h29,
  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned CW  = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                code_valid,
  input  logic [DW-1:0]       code_in,
  input  logic [CHW-1:0]      wr_ch,
  input  logic                clr,
  input  logic [CHW-1:0]      rd_ch,
  output logic [DEPTH*DW-1:0] rd_block,
  output logic [CW-1:0]       rd_count,
  output logic                full,
  output logic                ovf,
  output logic                blk_valid,
  input  logic                blk_ready,
  output logic [CHW-1:0]      blk_ch,
  output logic [DEPTH*DW-1:0] blk_data
);

  typedef enum logic {StIdle, StPend} state_e;

  logic [DW-1:0]       slots_q [NUM_CH][DEPTH];
  logic [DW-1:0]       slots_d [NUM_CH][DEPTH];
  logic [CW-1:0]       count_q [NUM_CH];
  logic [CW-1:0]       count_d [NUM_CH];
  logic                ovf_q, ovf_d;
  state_e              state_q, state_d;
  logic [CHW-1:0]      blk_ch_q, blk_ch_d;
  logic [DEPTH*DW-1:0] blk_data_q, blk_data_d;

  logic                wr_ok, rd_ok, enter_ok;
  logic [CW-1:0]       wr_cnt;
  logic [DEPTH*DW-1:0] wr_block;

  assign wr_ok = 32'(wr_ch) < NUM_CH;
  assign rd_ok = 32'(rd_ch) < NUM_CH;

  // Write-side and read-side channel muxes; out-of-range channels read as empty.
  always_comb begin
    wr_cnt   = '0;
    wr_block = {DEPTH{PAD_CODE}};
    rd_count = '0;
    rd_block = {DEPTH{PAD_CODE}};
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (wr_ok && CHW'(c) == wr_ch) begin
        wr_cnt = count_q[c];
        for (int unsigned i = 0; i < DEPTH; i++) wr_block[i*DW +: DW] = slots_q[c][i];
      end
      if (rd_ok && CHW'(c) == rd_ch) begin
        rd_count = count_q[c];
        for (int unsigned i = 0; i < DEPTH; i++) rd_block[i*DW +: DW] = slots_q[c][i];
      end
    end
  end

  assign full = wr_ok && (wr_cnt == CW'(DEPTH));

  always_comb begin
    slots_d = slots_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (wr_ok && CHW'(c) == wr_ch) begin
        if (clr) begin
          for (int unsigned i = 0; i < DEPTH; i++) slots_d[c][i] = PAD_CODE;
          count_d[c] = '0;
        end else if (code_valid) begin
          if (code_in == BKSP_CODE) begin
            if (count_q[c] != '0) begin
              count_d[c] = count_q[c] - CW'(1);
              for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CW'(i + 1) == count_q[c]) slots_d[c][i] = PAD_CODE;
              end
            end
          end else if (code_in != ENTER_CODE) begin
            if (count_q[c] == CW'(DEPTH)) begin
              ovf_d = 1'b1;
            end else begin
              count_d[c] = count_q[c] + CW'(1);
              for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CW'(i) == count_q[c]) slots_d[c][i] = code_in;
              end
            end
          end
        end
      end
    end
  end

  // clr takes priority, so an ENTER arriving with clr never commits.
  assign enter_ok = wr_ok && !clr && code_valid && (code_in == ENTER_CODE) && (wr_cnt != '0);

  always_comb begin
    state_d    = state_q;
    blk_ch_d   = blk_ch_q;
    blk_data_d = blk_data_q;
    unique case (state_q)
      StIdle: begin
        if (enter_ok) begin
          state_d    = StPend;
          blk_ch_d   = wr_ch;
          blk_data_d = wr_block;
        end
      end
      StPend: begin
        if (blk_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        count_q[c] <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) slots_q[c][i] <= PAD_CODE;
      end
      ovf_q      <= 1'b0;
      state_q    <= StIdle;
      blk_ch_q   <= '0;
      blk_data_q <= {DEPTH{PAD_CODE}};
    end else begin
      slots_q    <= slots_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      blk_ch_q   <= blk_ch_d;
      blk_data_q <= blk_data_d;
    end
  end

  assign ovf       = ovf_q;
  assign blk_valid = (state_q == StPend);
  assign blk_ch    = blk_ch_q;
  assign blk_data  = blk_data_q;

endmodule

// File: tb/tb_ps2_block_entry_buffer.sv
// Directed bench for ps2_block_entry_buffer with hand-computed expected blocks and counts.
module tb_ps2_block_entry_buffer;

  logic         clock, resetn;
  logic         code_valid, clr, blk_ready;
  logic [7:0]   code_in;
  logic         wr_ch, rd_ch;
  logic [127:0] rd_block, blk_data;
  logic [4:0]   rd_count;
  logic         full, ovf, blk_valid, blk_ch;

  int errors = 0;
  int checks = 0;

  logic [127:0] pad_blk, exp_blk, exp1;

  ps2_block_entry_buffer dut (
    .clock      (clock),
    .resetn     (resetn),
    .code_valid (code_valid),
    .code_in    (code_in),
    .wr_ch      (wr_ch),
    .clr        (clr),
    .rd_ch      (rd_ch),
    .rd_block   (rd_block),
    .rd_count   (rd_count),
    .full       (full),
    .ovf        (ovf),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_ch     (blk_ch),
    .blk_data   (blk_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic ch, input logic [7:0] c);
    wr_ch      = ch;
    code_in    = c;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
  endtask

  initial begin
    pad_blk    = {16{8'h29}};
    resetn     = 1'b0;
    code_valid = 1'b0;
    clr        = 1'b0;
    blk_ready  = 1'b0;
    code_in    = 8'h00;
    wr_ch      = 1'b0;
    rd_ch      = 1'b0;
    tick();
    tick();
    check("rst_count", 128'(rd_count), 128'd0);
    check("rst_block", rd_block, pad_blk);
    check("rst_valid", 128'(blk_valid), 128'd0);
    check("rst_bdata", blk_data, pad_blk);
    check("rst_ovf", 128'(ovf), 128'd0);
    resetn = 1'b1;
    tick();

    // 1) two codes into ch0
    strobe(1'b0, 8'h1C);
    strobe(1'b0, 8'h32);
    exp_blk = pad_blk;
    exp_blk[7:0]  = 8'h1C;
    exp_blk[15:8] = 8'h32;
    check("t1_block", rd_block, exp_blk);
    check("t1_count", 128'(rd_count), 128'd2);

    // 2) fill ch1 and overflow once
    rd_ch = 1'b1;
    exp1  = pad_blk;
    for (int i = 0; i < 16; i++) begin
      strobe(1'b1, 8'h10 + 8'(i));
      exp1[i*8 +: 8] = 8'h10 + 8'(i);
      if (i == 14) check("t2_notfull", 128'(full), 128'd0);
    end
    check("t2_full", 128'(full), 128'd1);
    check("t2_noovf", 128'(ovf), 128'd0);
    strobe(1'b1, 8'h44);
    check("t2_ovf", 128'(ovf), 128'd1);
    check("t2_block", rd_block, exp1);
    tick();
    check("t2_ovf_once", 128'(ovf), 128'd0);
    check("t2_count", 128'(rd_count), 128'd16);

    // 3) ch0 to 3 entries, then four backspaces
    rd_ch = 1'b0;
    strobe(1'b0, 8'h21);
    check("t3_count3", 128'(rd_count), 128'd3);
    for (int i = 0; i < 4; i++) begin
      strobe(1'b0, 8'h66);
      check("t3_bksp_count", 128'(rd_count), 128'((i < 3) ? 2 - i : 0));
      check("t3_bksp_ovf", 128'(ovf), 128'd0);
    end
    check("t3_block", rd_block, pad_blk);
    rd_ch = 1'b1;
    #1;
    check("t3_ch1_intact", rd_block, exp1);

    // 4) commit ch1, hold, edit while pending, then accept
    tick();
    check("t4_ready_idle", 128'(blk_valid), 128'd0);
    strobe(1'b1, 8'h5A);
    check("t4_valid", 128'(blk_valid), 128'd1);
    check("t4_ch", 128'(blk_ch), 128'd1);
    check("t4_data", blk_data, exp1);
    check("t4_enter_not_stored", 128'(rd_count), 128'd16);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold", 128'(blk_valid), 128'd1);
    end
    strobe(1'b1, 8'h66);
    exp_blk = exp1;
    exp_blk[127:120] = 8'h29;
    check("t4_edit_block", rd_block, exp_blk);
    check("t4_edit_count", 128'(rd_count), 128'd15);
    check("t4_data_stable", blk_data, exp1);
    check("t4_ch_stable", 128'(blk_ch), 128'd1);
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    check("t4_accept", 128'(blk_valid), 128'd0);
    // commit again, then ENTER on the accepting edge must not re-arm
    strobe(1'b1, 8'h5A);
    check("t4_data2", blk_data, exp_blk);
    blk_ready = 1'b1;
    strobe(1'b1, 8'h5A);
    blk_ready = 1'b0;
    check("t4_enter_on_accept", 128'(blk_valid), 128'd0);

    // 5) clr wins over code_valid; ENTER on empty channel ignored
    rd_ch = 1'b0;
    strobe(1'b0, 8'h33);
    check("t5_count1", 128'(rd_count), 128'd1);
    clr = 1'b1;
    strobe(1'b0, 8'h44);
    clr = 1'b0;
    check("t5_clr_count", 128'(rd_count), 128'd0);
    check("t5_clr_block", rd_block, pad_blk);
    strobe(1'b0, 8'h5A);
    check("t5_empty_enter", 128'(blk_valid), 128'd0);

    // 6) asynchronous reset while pending
    strobe(1'b1, 8'h5A);
    check("t6_pending", 128'(blk_valid), 128'd1);
    rd_ch = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_valid", 128'(blk_valid), 128'd0);
    check("t6_rst_count", 128'(rd_count), 128'd0);
    check("t6_rst_full", 128'(full), 128'd0);
    check("t6_rst_bdata", blk_data, pad_blk);
    tick();
    resetn = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
